gf180mcu_fd_sc_mcu9t5v0__cell4_bist: RTL

Built-in self-test sequencer for 4-input compound cells (OAI22, AOI22 and relatives) in the 9-track 5 V library. It sits on both sides of the cell under test: upstream, it drives A1/A2/B1/B2 with an exhaustive pattern sweep; downstream, it samples the cell's ZN. Each sample is checked against a parameterised truth table and compressed into a 16-bit MISR signature, for on-silicon characterisation and library bring-up.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__bist_pkg.sv | 27 ++
 rtl/gf180mcu_fd_sc_mcu9t5v0__bist_misr16.sv | 22 ++
 rtl/gf180mcu_fd_sc_mcu9t5v0__cell4_bist.sv | 108 ++++++++++
 3 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bist_pkg.sv
// Shared types and constants for the 4-input compound-cell BIST.
package gf180mcu_fd_sc_mcu9t5v0__bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Expected ZN per pattern index {A1,A2,B1,B2}; bit i is ZN for index i.
  // The 3-input variants treat B2 as don't-care.
  localparam logic [15:0] TRUTH_OAI22 = 16'h111F;
  localparam logic [15:0] TRUTH_AOI22 = 16'h0777;
  localparam logic [15:0] TRUTH_OAI21 = 16'h333F;
  localparam logic [15:0] TRUTH_AOI21 = 16'h0333;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // One MISR step absorbing a single serial bit.
  function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic d);
    logic fb;
    fb = sig[15] ^ d;
    return {sig[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bist_misr16.sv
// 16-bit single-input MISR with synchronous clear to the seed value.
module gf180mcu_fd_sc_mcu9t5v0__bist_misr16
  import gf180mcu_fd_sc_mcu9t5v0__bist_pkg::*;
(
  input  logic        CLK,
  input  logic        RN,
  input  logic        CLR,
  input  logic        EN,
  input  logic        D_IN,
  output logic [15:0] SIG
);

  // Signature register: reset/clear to seed, otherwise absorb D_IN when enabled.
  always_ff @(posedge CLK) begin
    if (!RN || CLR) begin
      SIG <= MISR_SEED;
    end else if (EN) begin
      SIG <= misr_step(SIG, D_IN);
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__cell4_bist.sv
// Exhaustive-pattern BIST sequencer for 4-input compound cells: drives
// A1/A2/B1/B2, checks ZN against a truth table and compresses it into a MISR.
module gf180mcu_fd_sc_mcu9t5v0__cell4_bist
  import gf180mcu_fd_sc_mcu9t5v0__bist_pkg::*;
#(
  parameter logic [15:0] TRUTH  = TRUTH_OAI22,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned PASSES = 1
) (
  input  logic        CLK,
  input  logic        RN,
  input  logic        START,
  input  logic        ZN_IN,
  output logic        A1,
  output logic        A2,
  output logic        B1,
  output logic        B2,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [7:0]  FAIL_CNT,
  output logic [15:0] SIGNATURE
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);
  localparam logic [7:0] LAST_PASS = 8'(PASSES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] pat;
  logic [3:0] settle;
  logic [7:0] pass_cnt;
  logic [7:0] fail_cnt;
  logic [3:0] stim;

  logic launch;
  logic sample;
  logic last;
  logic mismatch;

  // Run launch, sample strobe and end-of-run detection.
  always_comb begin
    launch   = (state != ST_RUN) && START;
    sample   = (state == ST_RUN) && (settle == '0);
    last     = sample && (pat == 4'hF) && (pass_cnt == LAST_PASS);
    mismatch = ZN_IN != TRUTH[pat];
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (START) state_nxt = ST_RUN;
      ST_RUN:           if (last)  state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Counters, comparator and registered stimulus; stim runs one pattern ahead
  // of pat's update so A1..B2 change on the same edge the pattern advances.
  always_ff @(posedge CLK) begin
    if (!RN || launch) begin
      pat      <= '0;
      settle   <= SETTLE_LD;
      pass_cnt <= '0;
      fail_cnt <= '0;
      stim     <= '0;
    end else if (state == ST_RUN) begin
      if (sample) begin
        if (mismatch && (fail_cnt != '1)) fail_cnt <= fail_cnt + 8'd1;
        pat    <= pat + 4'd1;
        settle <= SETTLE_LD;
        if (pat == 4'hF) pass_cnt <= pass_cnt + 8'd1;
        stim   <= last ? 4'h0 : pat + 4'd1;
      end else begin
        settle <= settle - 4'd1;
      end
    end
  end

  gf180mcu_fd_sc_mcu9t5v0__bist_misr16 u_misr (
    .CLK  (CLK),
    .RN   (RN),
    .CLR  (launch),
    .EN   (sample),
    .D_IN (ZN_IN),
    .SIG  (SIGNATURE)
  );

  // Status and stimulus outputs decoded from registered state.
  always_comb begin
    BUSY             = (state == ST_RUN);
    DONE             = (state == ST_DONE);
    PASS             = (state == ST_DONE) && (fail_cnt == '0);
    FAIL_CNT         = fail_cnt;
    {A1, A2, B1, B2} = stim;
  end

endmodule
